// File: rtl/grid_pkg.sv
// grid_pkg: shared grid constants, LFSR constants and the row_bias state type.
package grid_pkg;
    localparam int GRID_LEN = 9;
    localparam int IDX_W = $clog2(GRID_LEN);
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [2:0] {
        INIT    = 3'b001,
        SHUFFLE = 3'b010,
        READY   = 3'b100
    } row_bias_state_e;
endpackage

// File: rtl/bias_lfsr.sv
// bias_lfsr: 16-bit right-shifting Galois LFSR with seed load on reset.
// Ports: clock, reset (sync, active-low, loads seed), advance (step once),
//        seed (load value; zero is coerced to 1), q (current state).
module bias_lfsr
    import grid_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clock) begin
        if (!reset)
            q <= (seed == '0) ? LFSR_W'(1) : seed;
        else if (advance)
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
    end
endmodule

// File: rtl/row_bias.sv
// row_bias: per-row shuffled permutation of one-hot values serving tile requests.
// Ports: clock, reset (sync, active-low), start (reshuffle request pulse),
//        ready (permutation stable), rq_valtotry/biasidx (OR'ed tile request
//        and one-hot slot index), valtotry (registered one-hot candidate),
//        err (sticky protocol error).
module row_bias #(
    parameter int          GRID_LEN = grid_pkg::GRID_LEN,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                ready,
    input  logic                rq_valtotry,
    input  logic [GRID_LEN-1:0] biasidx,
    output logic [GRID_LEN-1:0] valtotry,
    output logic                err
);
    import grid_pkg::*;
    localparam int IW = $clog2(GRID_LEN);
    row_bias_state_e state;
    logic [GRID_LEN-1:0] perm [GRID_LEN];
    logic [GRID_LEN-1:0] pick;
    logic [IW-1:0] i, j;
    logic [LFSR_W-1:0] lfsr;
    bias_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .advance(state == SHUFFLE),
        .seed   (SEED),
        .q      (lfsr)
    );
    assign j = lfsr[IW-1:0];
    always_comb begin
        pick = '0;
        for (int k = 0; k < GRID_LEN; k++)
            pick = pick | (biasidx[k] ? perm[k] : '0);
    end
    // Rejection-sampled Fisher-Yates: one accepted swap per cycle, walking i down to 1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < GRID_LEN; k++)
                perm[k] <= GRID_LEN'(1) << k;
            i        <= IW'(GRID_LEN - 1);
            state    <= INIT;
            ready    <= 1'b0;
            valtotry <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                INIT: state <= SHUFFLE;
                SHUFFLE: if (j <= i) begin
                    perm[i] <= perm[j];
                    perm[j] <= perm[i];
                    if (i == IW'(1)) begin
                        state <= READY;
                        ready <= 1'b1;
                        i     <= IW'(GRID_LEN - 1);
                    end else
                        i <= i - 1'b1;
                end
                READY: if (start) begin
                    state <= SHUFFLE;
                    ready <= 1'b0;
                end
                default: state <= INIT;
            endcase
            if (rq_valtotry) begin
                valtotry <= ready ? pick : '0;
                // Multi-hot index means two tiles requested in the same cycle.
                if (!ready || (biasidx & (biasidx - 1'b1)) != '0)
                    err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_row_bias.sv
// tb_row_bias: directed/randomized self-checking bench for row_bias against a Fisher-Yates model.
module tb_row_bias;
    localparam logic [15:0] SEED = 16'hACE1;
    logic       clock = 1'b0;
    logic       reset, start, rq_valtotry, ready, err;
    logic [8:0] biasidx, valtotry;
    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;
    int mperm [9];
    int perm0 [9];
    int n0, n1, n2, c;
    logic [8:0] held;

    row_bias #(.GRID_LEN(9), .SEED(SEED)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .rq_valtotry(rq_valtotry),
        .biasidx    (biasidx),
        .valtotry   (valtotry),
        .err        (err)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] oh(input int v);
        logic [8:0] one;
        one = 9'd1;
        return one << v;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = SEED;
        for (int k = 0; k < 9; k++) mperm[k] = k;
    endtask

    // Draw j from the low bits of the LFSR each cycle, reject j > i, swap otherwise.
    task automatic model_shuffle(output int n);
        int i, j, t;
        i = 8;
        n = 0;
        while (n < 10000) begin
            j = int'(m_lfsr[3:0]);
            m_lfsr = lstep(m_lfsr);
            n++;
            if (j <= i) begin
                t = mperm[i]; mperm[i] = mperm[j]; mperm[j] = t;
                if (i == 1) break;
                i--;
            end
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 300) begin
            @(negedge clock);
            cnt++;
        end
        chk(tag, cnt, exp_n);
        chk({tag, "_ready"}, ready, 1);
    endtask

    task automatic check_perm(input string tag);
        logic [8:0] acc;
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            rq_valtotry = 1'b1;
            biasidx = oh(k);
            @(negedge clock);
            chk(tag, valtotry, oh(mperm[k]));
            chk({tag, "_onehot"}, $onehot(valtotry), 1);
            acc = acc | valtotry;
        end
        rq_valtotry = 1'b0;
        biasidx = '0;
        chk({tag, "_or"}, acc, 9'h1FF);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rq_valtotry = 1'b0; biasidx = '0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_ready", ready, 0);
            chk("rst_val", valtotry, 0);
            chk("rst_err", err, 0);
        end
        reset = 1'b1;
        model_reset();
        model_shuffle(n0);
        for (int k = 0; k < 9; k++) perm0[k] = mperm[k];
        wait_ready("boot_lat", 1 + n0);
        check_perm("boot");

        rq_valtotry = 1'b1; biasidx = 9'h004;
        @(negedge clock);
        chk("hold_first", valtotry, oh(mperm[2]));
        rq_valtotry = 1'b0;
        repeat (5) begin
            biasidx = 9'($urandom);
            @(negedge clock);
            chk("hold_stable", valtotry, oh(mperm[2]));
        end

        for (int r = 0; r < 24; r++) begin
            int k;
            k = $urandom_range(0, 9);
            rq_valtotry = 1'b1;
            biasidx = (k == 9) ? 9'h000 : oh(k);
            @(negedge clock);
            held = (k == 9) ? 9'h000 : oh(mperm[k]);
            chk("rand_req", valtotry, held);
            rq_valtotry = 1'b0;
            biasidx = 9'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                chk("rand_hold", valtotry, held);
            end
        end
        chk("rand_err", err, 0);

        rq_valtotry = 1'b1; biasidx = 9'h000;
        @(negedge clock);
        chk("probe_val", valtotry, 0);
        chk("probe_err", err, 0);
        biasidx = 9'h003;
        @(negedge clock);
        chk("multi_val", valtotry, oh(mperm[0]) | oh(mperm[1]));
        chk("multi_err", err, 1);
        rq_valtotry = 1'b0; biasidx = '0;
        repeat (3) @(negedge clock);
        chk("err_sticky", err, 1);

        reset = 1'b0;
        @(negedge clock);
        chk("rst2_err", err, 0);
        chk("rst2_val", valtotry, 0);
        reset = 1'b1;
        model_reset();
        model_shuffle(n0);
        wait_ready("boot2_lat", 1 + n0);

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_drop", ready, 0);
        model_shuffle(n1);
        c = 1;
        while (ready !== 1'b1 && c < 300) begin
            if (c == 1) begin
                rq_valtotry = 1'b1;
                biasidx = oh($urandom_range(0, 8));
            end
            @(negedge clock);
            c++;
            if (c == 2) begin
                chk("notready_val", valtotry, 0);
                chk("notready_err", err, 1);
                rq_valtotry = 1'b0;
                biasidx = '0;
            end
        end
        chk("restart_lat", c, n1 + 1);
        chk("restart_low8", c - 1 >= 8, 1);
        check_perm("reshuffle");

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_busy", ready, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ready", ready, 0);
        reset = 1'b1;
        model_reset();
        model_shuffle(n2);
        wait_ready("rerun_lat", 1 + n0);
        for (int k = 0; k < 9; k++) mperm[k] = perm0[k];
        check_perm("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
